// File: rtl/alu_result_tx.sv
// rtl/alu_result_tx.sv - buffers ALU status words and sends them as framed serial bits
module alu_result_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop_err
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Transmitter state
    logic [2:0]        state_q,  state_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [2:0]        bit_q,    bit_d;
    logic [7:0]        shift_q,  shift_d;
    logic              parity_q, parity_d;
    logic              tx_q,     tx_d;
    logic              busy_q,   busy_d;
    logic              drop_q;

    logic       push;
    logic       pop;
    logic       can_start;
    logic       baud_done;
    logic [7:0] head;

    // in_ready is forced low while reset is held since count is meaningless then
    assign in_ready  = rst_n && ena && (count_q < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign can_start = (count_q != '0) && ena;
    assign baud_done = (baud_q == '0);
    assign head      = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign drop_err   = drop_q;

    // FIFO data array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (in_valid && !in_ready) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Frame sequencer: start, 8 data bits LSB first, even parity, stop
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (can_start) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    baud_d  = BAUD_LAST;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                        tx_d    = parity_q;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    baud_d  = BAUD_LAST;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (can_start) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Popping the head always launches a new frame with its start bit
        if (pop) begin
            state_d  = S_START;
            shift_d  = head;
            parity_d = ^head;
            tx_d     = 1'b0;
            baud_d   = BAUD_LAST;
            bit_d    = 3'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Transmitter registers; reset returns the line to idle-high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// tb/tb_alu_result_tx.sv - scoreboard bench for alu_result_tx serial framing
module tb_alu_result_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 11 * CPB;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       drop_err;

    int checks = 0;
    int errors = 0;

    // {parity, data} of every word expected on the line, in order
    logic [8:0] exp_q[$];

    alu_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one strobe cycle and returns at the next negedge
    task automatic push_word(input logic [7:0] d, input logic p, input bit acc, input string nm);
        in_valid = 1'b1;
        in_data  = d;
        chk(nm, {31'd0, in_ready}, {31'd0, acc});
        if (acc) exp_q.push_back({p, d});
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] d, input logic p, input string nm);
        push_word(d, p, 1'b1, nm);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fifo_count != 3'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got timeout expected idle at %0t", $time);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: decodes each frame from tx and checks every cycle of it
    initial begin
        logic [10:0] fbits;
        logic [10:0] abits;
        logic [8:0]  e;
        int          idx;
        bit          active;
        bit          bad;
        bit          unexp;
        active = 0;
        idx    = 0;
        bad    = 0;
        unexp  = 0;
        fbits  = '0;
        abits  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
            end else begin
                if (!active && tx === 1'b0) begin
                    active = 1;
                    idx    = 0;
                    bad    = 0;
                    abits  = '0;
                    if (exp_q.size() == 0) begin
                        unexp = 1;
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got start bit expected idle at %0t", $time);
                    end else begin
                        unexp = 0;
                        e     = exp_q.pop_front();
                        fbits = {1'b1, e[8], e[7:0], 1'b0};
                    end
                end
                if (active) begin
                    if (!unexp && tx !== fbits[idx / CPB]) bad = 1;
                    if ((idx % CPB) == CPB / 2) abits[idx / CPB] = tx;
                    idx++;
                    if (idx == FRAME) begin
                        active = 0;
                        if (!unexp) begin
                            checks++;
                            if (bad) begin
                                errors++;
                                $display("FAIL frame_0x%02h: got bits %b expected %b", fbits[8:1], abits, fbits);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int  n;
        bit  quiet;
        rst_n    = 1'b0;
        ena      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_tx",       {31'd0, tx},       32'd1);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_count",    {29'd0, fifo_count}, 32'd0);
        chk("rst_drop",     {31'd0, drop_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 0xA5: latency, occupancy and frame length
        strobe(8'hA5, 1'b0, "a5_ready");
        chk("a5_count_e0", {29'd0, fifo_count}, 32'd1);
        chk("a5_tx_e0",    {31'd0, tx},         32'd1);
        @(negedge clk);
        chk("a5_count_e1", {29'd0, fifo_count}, 32'd0);
        chk("a5_tx_e1",    {31'd0, tx},         32'd0);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("a5_busy_len", n, 32'd44);
        wait_idle();

        strobe(8'h01, 1'b1, "w01_ready");
        wait_idle();
        strobe(8'h00, 1'b0, "w00_ready");
        wait_idle();

        // Five consecutive pushes: all accepted, frames back to back
        @(negedge clk);
        push_word(8'h11, 1'b0, 1'b1, "b2b_11");
        push_word(8'h22, 1'b0, 1'b1, "b2b_22");
        push_word(8'h33, 1'b0, 1'b1, "b2b_33");
        push_word(8'h44, 1'b0, 1'b1, "b2b_44");
        push_word(8'h55, 1'b0, 1'b1, "b2b_55");
        in_valid = 1'b0;
        chk("b2b_drop", {31'd0, drop_err}, 32'd0);
        n = 3;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_busy_len", n, 32'd220);
        wait_idle();

        // Overflow while a frame is in flight
        strobe(8'h07, 1'b1, "ovf_07");
        repeat (2) @(negedge clk);
        push_word(8'h80, 1'b1, 1'b1, "ovf_80");
        push_word(8'h01, 1'b1, 1'b1, "ovf_01");
        push_word(8'h22, 1'b0, 1'b1, "ovf_22");
        push_word(8'h33, 1'b0, 1'b1, "ovf_33");
        chk("ovf_count4", {29'd0, fifo_count}, 32'd4);
        push_word(8'hFF, 1'b0, 1'b0, "ovf_ready_low");
        in_valid = 1'b0;
        chk("ovf_drop_set", {31'd0, drop_err}, 32'd1);
        wait_idle();
        chk("ovf_drop_sticky", {31'd0, drop_err}, 32'd1);

        // ena dropped mid-frame with a word queued
        @(negedge clk);
        push_word(8'h3C, 1'b0, 1'b1, "ena_3c");
        push_word(8'h5A, 1'b0, 1'b1, "ena_5a");
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        ena = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("ena_held_count", {29'd0, fifo_count}, 32'd1);
        quiet = 1;
        repeat (20) begin
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 0;
            @(negedge clk);
        end
        chk("ena_line_quiet", {31'd0, quiet}, 32'd1);
        ena = 1'b1;
        @(negedge clk);
        chk("ena_resume_busy", {31'd0, busy}, 32'd1);
        chk("ena_resume_tx",   {31'd0, tx},   32'd0);
        wait_idle();

        // Asynchronous reset during the data bits
        strobe(8'hC3, 1'b0, "rst_c3");
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx",    {31'd0, tx},         32'd1);
        chk("arst_busy",  {31'd0, busy},       32'd0);
        chk("arst_count", {29'd0, fifo_count}, 32'd0);
        chk("arst_drop",  {31'd0, drop_err},   32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        strobe(8'h96, 1'b0, "post_rst_96");
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
